// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback sequencer.
package wb_pkg;

   localparam int unsigned WB_DATA_WIDTH = 32;
   localparam int unsigned WB_NUM_REGS   = 32;
   localparam int unsigned REG_ZERO      = 0;

   function automatic int unsigned wb_aw(input int unsigned num_regs);
      return (num_regs > 1) ? $clog2(num_regs) : 1;
   endfunction

   typedef struct packed {
      logic [wb_aw(WB_NUM_REGS)-1:0] rd;
      logic [WB_DATA_WIDTH-1:0]      wd;
   } wb_entry_t;

endpackage

// File: rtl/wb_sequencer_if.sv
// Bus bundle between the pipeline (master) and the writeback sequencer (slave).
interface wb_sequencer_if
   import wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32
);
   localparam int unsigned AW = wb_aw(NUM_REGS);

   logic                  alu_we;
   logic [AW-1:0]         alu_rd;
   logic [DATA_WIDTH-1:0] alu_wd;
   logic                  issue_valid;
   logic [AW-1:0]         issue_rd;
   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [AW-1:0]         lsu_rd;
   logic [DATA_WIDTH-1:0] lsu_wd;
   logic [AW-1:0]         rs1;
   logic [AW-1:0]         rs2;
   logic                  stall;
   logic                  alu_hold;
   logic [AW-1:0]         rf_a3;
   logic [DATA_WIDTH-1:0] rf_wd3;
   logic                  rf_we3;

   modport master (
      output alu_we, alu_rd, alu_wd, issue_valid, issue_rd,
             lsu_valid, lsu_rd, lsu_wd, rs1, rs2,
      input  lsu_ready, stall, alu_hold, rf_a3, rf_wd3, rf_we3
   );

   modport slave (
      input  alu_we, alu_rd, alu_wd, issue_valid, issue_rd,
             lsu_valid, lsu_rd, lsu_wd, rs1, rs2,
      output lsu_ready, stall, alu_hold, rf_a3, rf_wd3, rf_we3
   );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency writeback entries; wrap-bit pointers.
module wb_fifo
   import wb_pkg::*;
#(
   parameter type         entry_t    = wb_entry_t,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output logic   full,
   output logic   empty,
   output entry_t head
);
   localparam int unsigned IW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = IW + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("wb_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   entry_t        mem [FIFO_DEPTH];
   logic          do_push;
   logic          do_pop;

   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      head    = mem[rd_ptr[IW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IW-1:0]] <= din;
   end

endmodule

// File: rtl/wb_sequencer.sv
// Register-file write sequencer: ALU/long-latency arbitration plus pending scoreboard.
// Optional anti-starvation hold is enabled by defining WB_ANTISTARVE_EN.
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_STARVE = 8
) (
   input logic           clk,
   input logic           rst,
   wb_sequencer_if.slave bus
);
   localparam int unsigned   AW = wb_aw(NUM_REGS);
   localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

   if (MAX_STARVE < 2) begin : g_bad_starve
      $error("wb_sequencer: MAX_STARVE must be >= 2");
   end

   typedef struct packed {
      logic [AW-1:0]         rd;
      logic [DATA_WIDTH-1:0] wd;
   } entry_t;

   entry_t                fifo_din;
   entry_t                head;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic [NUM_REGS-1:0]   pend;
   logic [NUM_REGS-1:0]   pend_next;
   logic                  we_q;
   logic [AW-1:0]         a3_q;
   logic [DATA_WIDTH-1:0] wd3_q;

   always_comb begin
      fifo_din.rd = bus.lsu_rd;
      fifo_din.wd = bus.lsu_wd;
      push        = bus.lsu_valid && !full;
      pop         = !bus.alu_we && !empty;
   end

   wb_fifo #(
      .entry_t    (entry_t),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q  <= 1'b0;
         a3_q  <= '0;
         wd3_q <= '0;
      end else if (bus.alu_we) begin
         we_q  <= (bus.alu_rd != RZ);
         a3_q  <= bus.alu_rd;
         wd3_q <= bus.alu_wd;
      end else if (pop) begin
         we_q  <= (head.rd != RZ);
         a3_q  <= head.rd;
         wd3_q <= head.wd;
      end else begin
         we_q  <= 1'b0;
      end
   end

   // Set is applied after clear: a same-edge issue belongs to a newer op.
   always_comb begin
      pend_next = pend;
      if (pop) pend_next[head.rd] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != RZ) pend_next[bus.issue_rd] = 1'b1;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= '0;
      else     pend <= pend_next;
   end

   always_comb begin
      bus.stall     = ((bus.rs1 != RZ) && pend[bus.rs1]) ||
                      ((bus.rs2 != RZ) && pend[bus.rs2]);
      bus.lsu_ready = !full;
      bus.rf_we3    = we_q;
      bus.rf_a3     = a3_q;
      bus.rf_wd3    = wd3_q;
   end

`ifdef WB_ANTISTARVE_EN
   localparam int unsigned SW = $clog2(MAX_STARVE) + 1;

   logic [SW-1:0] starve_cnt;
   logic          hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         hold_q     <= 1'b0;
      end else begin
         hold_q <= 1'b0;
         if (pop || empty) begin
            starve_cnt <= '0;
         end else if (bus.alu_we) begin
            if (starve_cnt == SW'(MAX_STARVE - 1)) begin
               hold_q     <= 1'b1;
               starve_cnt <= '0;
            end else begin
               starve_cnt <= starve_cnt + SW'(1);
            end
         end
      end
   end

   assign bus.alu_hold = hold_q;
`else
   assign bus.alu_hold = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed self-checking bench for wb_sequencer (table vectors plus multi-cycle sequences).
module tb_wb_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   wb_sequencer_if #(.DATA_WIDTH(32), .NUM_REGS(32)) bus ();

   wb_sequencer #(
      .DATA_WIDTH (32),
      .NUM_REGS   (32),
      .FIFO_DEPTH (4),
      .MAX_STARVE (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alu_we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        exp_we;
      logic        chk_data;
      logic [4:0]  exp_a3;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_we      = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_wd      = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = '0;
      bus.lsu_wd      = '0;
   endtask

   task automatic check_write(input string name, input logic [4:0] a3, input logic [31:0] wd);
      check({name, "_we"}, 32'(bus.rf_we3), 32'd1);
      check({name, "_a3"}, 32'(bus.rf_a3), 32'(a3));
      check({name, "_wd"}, bus.rf_wd3, wd);
   endtask

   int unsigned n;

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
      vecs[1] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 1'b1, 5'd31, 32'h00000001};
      vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd31, 32'h00000001};
      vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  32'h0};
      vecs[4] = '{1'b1, 5'd1,  32'hA5A5A5A5, 1'b1, 1'b1, 5'd1,  32'hA5A5A5A5};
      vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd1,  32'hA5A5A5A5};

      idle_inputs();
      bus.rs1 = 5'd5;
      bus.rs2 = 5'd10;
      rst = 1'b1;
      #12;
      check("rst_we",    32'(bus.rf_we3),    32'd0);
      check("rst_a3",    32'(bus.rf_a3),     32'd0);
      check("rst_wd",    bus.rf_wd3,         32'd0);
      check("rst_ready", 32'(bus.lsu_ready), 32'd1);
      check("rst_stall", 32'(bus.stall),     32'd0);
      check("rst_hold",  32'(bus.alu_hold),  32'd0);
      rst = 1'b0;
      tick();

      // ALU-only vectors
      for (int i = 0; i < 6; i++) begin
         bus.alu_we = vecs[i].alu_we;
         bus.alu_rd = vecs[i].rd;
         bus.alu_wd = vecs[i].wd;
         tick();
         check($sformatf("vec%0d_we", i), 32'(bus.rf_we3), 32'(vecs[i].exp_we));
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d_a3", i), 32'(bus.rf_a3), 32'(vecs[i].exp_a3));
            check($sformatf("vec%0d_wd", i), bus.rf_wd3, vecs[i].exp_wd);
         end
      end
      check("alu_no_stall", 32'(bus.stall), 32'd0);

      // Load path
      idle_inputs();
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd10;
      tick();
      bus.issue_valid = 1'b0;
      bus.rs1 = 5'd10;
      bus.rs2 = 5'd0;
      #1;
      check("load_stall_set", 32'(bus.stall), 32'd1);
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd10;
      bus.lsu_wd    = 32'h1234;
      tick();
      bus.lsu_valid = 1'b0;
      check("load_push_we", 32'(bus.rf_we3), 32'd0);
      check("load_stall_hold", 32'(bus.stall), 32'd1);
      tick();
      check_write("load_pop", 5'd10, 32'h1234);
      check("load_stall_clr", 32'(bus.stall), 32'd0);

      // Priority: ALU holds off the FIFO head for three cycles
      bus.rs1 = 5'd0;
      bus.alu_we    = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.alu_wd    = 32'h31;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd7;
      bus.lsu_wd    = 32'h77;
      tick();
      bus.lsu_valid = 1'b0;
      check_write("prio_alu1", 5'd3, 32'h31);
      bus.alu_wd = 32'h32;
      tick();
      check_write("prio_alu2", 5'd3, 32'h32);
      bus.alu_wd = 32'h33;
      tick();
      check_write("prio_alu3", 5'd3, 32'h33);
      bus.alu_we = 1'b0;
      tick();
      check_write("prio_pop", 5'd7, 32'h77);
      tick();
      check("prio_idle_we", 32'(bus.rf_we3), 32'd0);

      // Full FIFO with pointer wrap
      bus.alu_we = 1'b1;
      bus.alu_rd = 5'd2;
      bus.alu_wd = 32'h22;
      bus.lsu_valid = 1'b1;
      for (int i = 11; i <= 14; i++) begin
         bus.lsu_rd = 5'(i);
         bus.lsu_wd = 32'h100 + 32'(i);
         tick();
      end
      check("full_ready0", 32'(bus.lsu_ready), 32'd0);
      bus.lsu_rd = 5'd15;
      bus.lsu_wd = 32'h10F;
      tick();
      check("full_blocked", 32'(bus.lsu_ready), 32'd0);
      bus.alu_we = 1'b0;
      tick();
      check_write("full_pop11", 5'd11, 32'h10B);
      check("full_ready1", 32'(bus.lsu_ready), 32'd1);
      tick();
      bus.lsu_valid = 1'b0;
      check_write("full_pop12", 5'd12, 32'h10C);
      for (int i = 13; i <= 15; i++) begin
         tick();
         check_write($sformatf("full_pop%0d", i), 5'(i), 32'h100 + 32'(i));
      end
      tick();
      check("full_drained_we", 32'(bus.rf_we3), 32'd0);

      // x0 entry still pops
      bus.alu_we    = 1'b1;
      bus.alu_rd    = 5'd2;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd0;
      bus.lsu_wd    = 32'hAB;
      tick();
      bus.alu_we = 1'b0;
      bus.lsu_rd = 5'd6;
      bus.lsu_wd = 32'h66;
      tick();
      bus.lsu_valid = 1'b0;
      check("x0_pop_we", 32'(bus.rf_we3), 32'd0);
      tick();
      check_write("x0_next", 5'd6, 32'h66);

      // Set wins over same-edge clear
      bus.alu_we      = 1'b1;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd9;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'd9;
      bus.lsu_wd      = 32'h99;
      tick();
      bus.alu_we    = 1'b0;
      bus.lsu_valid = 1'b0;
      tick();
      bus.issue_valid = 1'b0;
      check_write("setwin_pop", 5'd9, 32'h99);
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd9;
      #1;
      check("setwin_stall", 32'(bus.stall), 32'd1);
      bus.alu_we    = 1'b1;
      bus.lsu_valid = 1'b1;
      bus.lsu_wd    = 32'h9A;
      tick();
      bus.alu_we    = 1'b0;
      bus.lsu_valid = 1'b0;
      tick();
      check_write("clr9_pop", 5'd9, 32'h9A);
      check("clr9_stall", 32'(bus.stall), 32'd0);
      bus.rs2 = 5'd0;

      // Starvation scenario
      bus.alu_we    = 1'b1;
      bus.alu_rd    = 5'd3;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = 5'd25;
      bus.lsu_wd    = 32'h25;
      tick();
      bus.lsu_valid = 1'b0;
`ifdef WB_ANTISTARVE_EN
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.alu_hold) begin
            n = i;
            break;
         end
      end
      check("starve_hold_cycle", n, 32'd8);
      bus.alu_we = 1'b0;
      tick();
      check_write("starve_pop", 5'd25, 32'h25);
      check("starve_hold_pulse", 32'(bus.alu_hold), 32'd0);
`else
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("nohold%0d", i), 32'(bus.alu_hold), 32'd0);
      end
      bus.alu_we = 1'b0;
      tick();
      check_write("starve_pop", 5'd25, 32'h25);
`endif

      // Reset mid-operation
      bus.alu_we      = 1'b1;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd21;
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'd20;
      bus.lsu_wd      = 32'h20;
      tick();
      idle_inputs();
      bus.rs1 = 5'd21;
      #1;
      check("mid_stall_pre", 32'(bus.stall), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_we",    32'(bus.rf_we3),    32'd0);
      check("mid_rst_a3",    32'(bus.rf_a3),     32'd0);
      check("mid_rst_ready", 32'(bus.lsu_ready), 32'd1);
      check("mid_rst_stall", 32'(bus.stall),     32'd0);
      #1;
      rst = 1'b0;
      tick();
      check("mid_post_we", 32'(bus.rf_we3), 32'd0);
      tick();
      check("mid_post_we2", 32'(bus.rf_we3), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
